// File: rtl/matvec_pkg.sv
// matvec_pkg: shared types and helpers for the matrix-vector multiply engine.
//   - state_e    : sequencer states (IDLE, CLEAR, RUN, DONE)
//   - operand_t / product_t / acc_t : default-width datapath types
//   - matvec_params_legal() : parameter legality check used at elaboration
// Optional feature macro: MATVEC_SIGNED_EN (two's complement operands).
package matvec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ACC_WIDTH  = 24;

  typedef logic [DEF_DATA_WIDTH-1:0]   operand_t;
  typedef logic [2*DEF_DATA_WIDTH-1:0] product_t;
  typedef logic [DEF_ACC_WIDTH-1:0]    acc_t;

  function automatic bit matvec_params_legal(input int rows, input int cols,
                                             input int dw, input int aw,
                                             input int depth);
    return (rows >= 2) && (cols >= 1) && (dw >= 1) &&
           (aw >= 2*dw) && (depth >= cols) && (depth >= 2);
  endfunction

endpackage

// File: rtl/matvec_fifo.sv
// matvec_fifo: show-ahead FIFO with count-based full/empty.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_wr_en/i_wr_data : write strobe/data (dropped when full)
//   i_rd_en         : pop (ignored when empty)
//   o_rd_data       : head entry, visible combinationally
//   o_count         : occupancy
//   o_full          : occupancy == DEPTH
//   o_drop          : write attempted while full (this cycle)
module matvec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_rd;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_wr      = i_wr_en && !w_full;
  assign w_rd      = i_rd_en && !w_empty;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_full    = w_full;
  assign o_drop    = i_wr_en && w_full;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/matvec_mac.sv
// matvec_mac: one systolic MAC stage.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   i_clr       : zero accumulator and pass-through valid
//   i_valid     : operand pair valid; accumulates A*B at this edge
//   i_a, i_b    : operands
//   o_b/o_valid : registered B pass-through to the next stage
//   o_acc_nxt   : value the accumulator holds after this edge
// Optional feature macro: MATVEC_SIGNED_EN (signed operands, sign-extended product).
module matvec_mac
  import matvec_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_b,
  output logic                  o_valid,
  output logic [ACC_WIDTH-1:0]  o_acc_nxt
);

  localparam int PW = 2*DATA_WIDTH;

  logic [ACC_WIDTH-1:0]  r_acc;
  logic [DATA_WIDTH-1:0] r_b;
  logic                  r_valid;
  logic [ACC_WIDTH-1:0]  w_prod_ext;
  logic [ACC_WIDTH-1:0]  w_acc_nxt;

`ifdef MATVEC_SIGNED_EN
  logic signed [PW-1:0] w_prod;
  assign w_prod     = PW'($signed(i_a)) * PW'($signed(i_b));
  assign w_prod_ext = ACC_WIDTH'(w_prod);
`else
  logic [PW-1:0] w_prod;
  assign w_prod     = PW'(i_a) * PW'(i_b);
  assign w_prod_ext = ACC_WIDTH'(w_prod);
`endif

  assign w_acc_nxt = i_clr   ? '0 :
                     i_valid ? r_acc + w_prod_ext : r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_b     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_acc   <= w_acc_nxt;
      r_b     <= i_clr ? '0 : i_b;
      r_valid <= i_clr ? 1'b0 : i_valid;
    end
  end

  assign o_b       = r_b;
  assign o_valid   = r_valid;
  assign o_acc_nxt = w_acc_nxt;

endmodule

// File: rtl/matvec_engine.sv
// matvec_engine: C[i] = sum_j A[i][j]*B[j] on a systolic chain of ROWS MACs.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   a_wr_en/row/data    : write into A FIFO a_wr_row
//   b_wr_en/b_wr_data   : write into B FIFO
//   start               : begin an operation (IDLE only)
//   a_full, b_full      : FIFO full flags
//   busy, done, err     : sequencer status; err is sticky until rst
//   c_rd_idx/c_rd_data  : registered result readout
// Optional feature macro: MATVEC_SIGNED_EN (two's complement arithmetic).
//
// state | meaning
// IDLE  | wait for start with all FIFOs holding >= COLS entries
// CLEAR | zero accumulators and skew valids
// RUN   | ROWS+COLS-1 cycles: pop B for COLS cycles, skewed MACs accumulate
// DONE  | one-cycle done pulse, results valid
module matvec_engine
  import matvec_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_wr_en,
  input  logic [$clog2(ROWS)-1:0] a_wr_row,
  input  logic [DATA_WIDTH-1:0]   a_wr_data,
  input  logic                    b_wr_en,
  input  logic [DATA_WIDTH-1:0]   b_wr_data,
  input  logic                    start,
  output logic [ROWS-1:0]         a_full,
  output logic                    b_full,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic [$clog2(ROWS)-1:0] c_rd_idx,
  output logic [ACC_WIDTH-1:0]    c_rd_data
);

  localparam int IW  = $clog2(ROWS);
  localparam int CW  = $clog2(ROWS+COLS);
  localparam int FCW = $clog2(FIFO_DEPTH+1);
  localparam logic [CW-1:0] RUN_LOAD = CW'(ROWS+COLS-2);
  // B is popped while the down-counter is still >= ROWS-1 (first COLS cycles).
  localparam logic [CW-1:0] B_POP_MIN = CW'(ROWS-1);

  if (!matvec_params_legal(ROWS, COLS, DATA_WIDTH, ACC_WIDTH, FIFO_DEPTH)) begin : g_param_err
    $error("matvec_engine: illegal parameter combination");
  end

  state_e               r_state;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic [CW-1:0]        r_run_cnt;
  logic [ACC_WIDTH-1:0] r_c_rd;

  logic [ROWS-1:0]       w_a_wr;
  logic [ROWS-1:0]       w_a_full;
  logic [ROWS-1:0]       w_a_drop;
  logic [ROWS-1:0]       w_a_ready;
  logic [DATA_WIDTH-1:0] w_a_head  [ROWS];
  logic [FCW-1:0]        w_a_count [ROWS];

  logic [DATA_WIDTH-1:0] w_b_head;
  logic [FCW-1:0]        w_b_count;
  logic                  w_b_full;
  logic                  w_b_drop;
  logic                  w_b_pop;

  // Index i feeds MAC i; index ROWS is the dangling output of the last stage.
  logic [DATA_WIDTH-1:0] w_chain_b [ROWS+1];
  logic [ROWS:0]         w_chain_v;
  logic [ACC_WIDTH-1:0]  w_acc_nxt [ROWS];
  logic [DATA_WIDTH:0]   w_unused_tail;

  logic w_clr;
  logic w_all_ready;
  logic w_wr_drop;
  logic w_idx_ok;

  assign w_clr   = (r_state == CLEAR);
  assign w_b_pop = (r_state == RUN) && (r_run_cnt >= B_POP_MIN);

  assign w_chain_b[0] = w_b_head;
  assign w_chain_v[0] = w_b_pop;
  assign w_unused_tail = {w_chain_v[ROWS], w_chain_b[ROWS]};

  matvec_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_b_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (b_wr_en),
    .i_wr_data (b_wr_data),
    .i_rd_en   (w_b_pop),
    .o_rd_data (w_b_head),
    .o_count   (w_b_count),
    .o_full    (w_b_full),
    .o_drop    (w_b_drop)
  );

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    assign w_a_wr[i]    = a_wr_en && (a_wr_row == IW'(i));
    assign w_a_ready[i] = (w_a_count[i] >= FCW'(COLS));

    // Row i pops its A entry in the same cycle its skewed B arrives.
    matvec_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_a_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_a_wr[i]),
      .i_wr_data (a_wr_data),
      .i_rd_en   (w_chain_v[i]),
      .o_rd_data (w_a_head[i]),
      .o_count   (w_a_count[i]),
      .o_full    (w_a_full[i]),
      .o_drop    (w_a_drop[i])
    );

    matvec_mac #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_clr),
      .i_valid   (w_chain_v[i]),
      .i_a       (w_a_head[i]),
      .i_b       (w_chain_b[i]),
      .o_b       (w_chain_b[i+1]),
      .o_valid   (w_chain_v[i+1]),
      .o_acc_nxt (w_acc_nxt[i])
    );
  end

  assign w_all_ready = (&w_a_ready) && (w_b_count >= FCW'(COLS));
  assign w_wr_drop   = (|w_a_drop) || w_b_drop;
  assign w_idx_ok    = ({1'b0, c_rd_idx} < (IW+1)'(ROWS));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_run_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_wr_drop) r_err <= 1'b1;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_all_ready) begin
              r_state <= CLEAR;
              r_busy  <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        CLEAR: begin
          r_state   <= RUN;
          r_run_cnt <= RUN_LOAD;
        end
        RUN: begin
          if (r_run_cnt == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_run_cnt <= r_run_cnt - CW'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Reading the post-edge accumulator value makes the final column of the
  // last row visible in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) r_c_rd <= '0;
    else     r_c_rd <= w_idx_ok ? w_acc_nxt[c_rd_idx] : '0;
  end

  assign a_full    = w_a_full;
  assign b_full    = w_b_full;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign c_rd_data = r_c_rd;

endmodule
